// File: rtl/mcb_port_emulator.sv
// mcb_port_emulator: block-RAM stand-in for the single-port DRAM controller
// user interface (p0_ command, write-data and read-data channels).
// Commands are queued, write bursts are committed into RAM once their data
// is present, and read bursts stream into a first-word-fall-through FIFO.
// Optional feature: define MCB_EMU_RANDOM_STALL_EN to add LFSR-driven stall
// cycles in the transfer states (and matching p0_cmd_full pulses).
// Handshake: a push/pop strobe takes effect on the rising edge where it is
// sampled high, provided the matching full/empty flag is low in that cycle.

// Synchronous FIFO with registered count/full/empty and a FWFT head output.
module mcb_emu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push)
            count_d = count_q - CNT_ONE;
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage is not reset; only the pointers define valid content.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;
endmodule

module mcb_port_emulator #(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          CMD_DEPTH    = 4,
    parameter int          WR_DEPTH     = 64,
    parameter int          RD_DEPTH     = 64,
    parameter int          CALIB_CYCLES = 100,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        calib_done,
    input  logic                        p0_cmd_en,
    input  logic [2:0]                  p0_cmd_instr,
    input  logic [29:0]                 p0_cmd_byte_addr,
    input  logic [5:0]                  p0_cmd_bl,
    output logic                        p0_cmd_full,
    input  logic                        p0_wr_en,
    input  logic [31:0]                 p0_wr_data,
    input  logic [3:0]                  p0_wr_mask,
    output logic                        p0_wr_full,
    output logic [$clog2(WR_DEPTH):0]   p0_wr_count,
    input  logic                        p0_rd_en,
    output logic [31:0]                 p0_rd_data,
    output logic                        p0_rd_empty,
    output logic [$clog2(RD_DEPTH):0]   p0_rd_count,
    output logic                        wr_overflow,
    output logic                        rd_underrun
);
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_WAIT, S_WR_XFER, S_RD_WAIT, S_RD_XFER, S_RD_DRAIN
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [6:0]             remaining_q;
    logic                   rvalid_q;
    logic [31:0]            ram_rdata_q;
    logic [31:0]            ram_q [2**ADDR_WIDTH];
    logic                   calib_q;
    logic [CAL_W-1:0]       cal_cnt_q;
    logic                   ovf_q, und_q;
    logic                   stall;

    logic [38:0]            cmd_dout;
    logic                   cmd_full, cmd_empty, cmd_pop;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic [35:0]            wr_dout;
    logic                   wr_full_f, wr_empty_f, wr_pop;
    logic [31:0]            rd_dout;
    logic                   rd_full_f, rd_issue;

    logic [2:0]             cmd_instr;
    logic [29:0]            cmd_addr;
    logic [5:0]             cmd_bl;

    assign cmd_instr = cmd_dout[38:36];
    assign cmd_addr  = cmd_dout[35:6];
    assign cmd_bl    = cmd_dout[5:0];

`ifdef MCB_EMU_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    // Fibonacci LFSR, taps 16,14,13,11; free-running from reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign p0_cmd_full = ~calib_q | cmd_full | stall;
    assign p0_wr_full  = ~calib_q | wr_full_f;
    assign calib_done  = calib_q;
    assign cmd_pop     = (state_q == S_IDLE) & ~cmd_empty;
    assign wr_pop      = (state_q == S_WR_XFER) & ~stall;
    assign rd_issue    = (state_q == S_RD_XFER) & ~stall;
    assign p0_rd_data  = p0_rd_empty ? 32'h0 : rd_dout;
    assign wr_overflow = ovf_q;
    assign rd_underrun = und_q;

    mcb_emu_fifo #(.WIDTH(39), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .reset(reset),
        .push_i(p0_cmd_en & ~p0_cmd_full),
        .din_i({p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl}),
        .pop_i(cmd_pop), .dout_o(cmd_dout),
        .full_o(cmd_full), .empty_o(cmd_empty), .count_o(cmd_count)
    );

    mcb_emu_fifo #(.WIDTH(36), .DEPTH(WR_DEPTH)) u_wr_fifo (
        .clk(clk), .reset(reset),
        .push_i(p0_wr_en & ~p0_wr_full),
        .din_i({p0_wr_mask, p0_wr_data}),
        .pop_i(wr_pop), .dout_o(wr_dout),
        .full_o(wr_full_f), .empty_o(wr_empty_f), .count_o(p0_wr_count)
    );

    mcb_emu_fifo #(.WIDTH(32), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk(clk), .reset(reset),
        .push_i(rvalid_q), .din_i(ram_rdata_q),
        .pop_i(p0_rd_en), .dout_o(rd_dout),
        .full_o(rd_full_f), .empty_o(p0_rd_empty), .count_o(p0_rd_count)
    );

    // Calibration timer: calib_done rises on clock CALIB_CYCLES after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
        end else if (!calib_q) begin
            cal_cnt_q <= cal_cnt_q + CAL_W'(1);
            if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
        end
    end

    // Sticky error flags for dropped pushes and ignored pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            if ((p0_cmd_en && p0_cmd_full) || (p0_wr_en && p0_wr_full)) ovf_q <= 1'b1;
            if (p0_rd_en && p0_rd_empty) und_q <= 1'b1;
        end
    end

    // Burst engine: one command at a time, one word per cycle while transferring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_issue;
            case (state_q)
                S_IDLE: begin
                    if (!cmd_empty) begin
                        addr_q      <= cmd_addr[ADDR_WIDTH+1:2];
                        remaining_q <= {1'b0, cmd_bl} + 7'd1;
                        case (cmd_instr)
                            3'b000, 3'b010: state_q <= S_WR_WAIT;
                            3'b001, 3'b011: state_q <= S_RD_WAIT;
                            default:        state_q <= S_IDLE;
                        endcase
                    end
                end
                S_WR_WAIT: begin
                    if (int'(p0_wr_count) >= int'(remaining_q)) state_q <= S_WR_XFER;
                end
                S_WR_XFER: begin
                    if (!stall) begin
                        addr_q      <= addr_q + ADDR_ONE;
                        remaining_q <= remaining_q - 7'd1;
                        if (remaining_q == 7'd1) state_q <= S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    if (RD_DEPTH - int'(p0_rd_count) >= int'(remaining_q)) state_q <= S_RD_XFER;
                end
                S_RD_XFER: begin
                    if (!stall) begin
                        addr_q      <= addr_q + ADDR_ONE;
                        remaining_q <= remaining_q - 7'd1;
                        if (remaining_q == 7'd1) state_q <= S_RD_DRAIN;
                    end
                end
                S_RD_DRAIN: state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // Backing RAM: byte-masked writes, registered reads; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_pop) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_dout[32+b]) ram_q[addr_q][8*b +: 8] <= wr_dout[8*b +: 8];
            end
        end
        if (rd_issue) ram_rdata_q <= ram_q[addr_q];
    end

    // Address bits outside the RAM window and spare FIFO status are not needed.
    logic unused_ok;
    assign unused_ok = ^{cmd_addr[29:ADDR_WIDTH+2], cmd_addr[1:0], cmd_count,
                         wr_empty_f, rd_full_f, LFSR_SEED[0]};
endmodule

// File: tb/tb_mcb_port_emulator.sv
// Directed bench for mcb_port_emulator: calibration timing, write/read
// bursts, byte masking, data-wait, address wrap, read latency and the
// sticky overflow/underrun flags. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_mcb_port_emulator;
    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [29:0] p0_cmd_byte_addr;
    logic [5:0]  p0_cmd_bl;
    logic        p0_cmd_full;
    logic        p0_wr_en;
    logic [31:0] p0_wr_data;
    logic [3:0]  p0_wr_mask;
    logic        p0_wr_full;
    logic [6:0]  p0_wr_count;
    logic        p0_rd_en;
    logic [31:0] p0_rd_data;
    logic        p0_rd_empty;
    logic [6:0]  p0_rd_count;
    logic        wr_overflow;
    logic        rd_underrun;

    int n_checks = 0;
    int n_fail   = 0;

    mcb_port_emulator dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
        .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_full(p0_cmd_full),
        .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
        .p0_wr_full(p0_wr_full), .p0_wr_count(p0_wr_count),
        .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty),
        .p0_rd_count(p0_rd_count),
        .wr_overflow(wr_overflow), .rd_underrun(rd_underrun)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: entered and left on a falling edge.
    task automatic wr_word(input logic [31:0] d, input logic [3:0] m);
        p0_wr_en = 1'b1; p0_wr_data = d; p0_wr_mask = m;
        @(negedge clk);
        p0_wr_en = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] instr, input logic [29:0] addr, input logic [5:0] bl);
        p0_cmd_en = 1'b1; p0_cmd_instr = instr; p0_cmd_byte_addr = addr; p0_cmd_bl = bl;
        @(negedge clk);
        p0_cmd_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk(tag, {32'h0, p0_rd_data}, {32'h0, exp});
        p0_rd_en = 1'b1;
        @(negedge clk);
        p0_rd_en = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        int k = 0;
        while (int'(p0_rd_count) < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wait_rd", {63'h0, int'(p0_rd_count) >= n}, 64'h1);
    endtask

    initial begin
        reset = 1'b1;
        p0_cmd_en = 1'b0; p0_cmd_instr = '0; p0_cmd_byte_addr = '0; p0_cmd_bl = '0;
        p0_wr_en = 1'b0; p0_wr_data = '0; p0_wr_mask = '0; p0_rd_en = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_calib", calib_done, 0);
        chk("rst_cmd_full", p0_cmd_full, 1);
        chk("rst_wr_full", p0_wr_full, 1);
        chk("rst_rd_empty", p0_rd_empty, 1);
        chk("rst_wr_count", p0_wr_count, 0);
        chk("rst_rd_count", p0_rd_count, 0);
        chk("rst_rd_data", p0_rd_data, 0);
        chk("rst_ovf", wr_overflow, 0);
        chk("rst_und", rd_underrun, 0);

        // Calibration completes exactly on clock 100
        reset = 1'b0;
        repeat (99) @(negedge clk);
        chk("cal99_done", calib_done, 0);
        chk("cal99_cmd_full", p0_cmd_full, 1);
        chk("cal99_wr_full", p0_wr_full, 1);
        @(negedge clk);
        chk("cal100_done", calib_done, 1);
        chk("cal100_cmd_full", p0_cmd_full, 0);
        chk("cal100_wr_full", p0_wr_full, 0);

        // Reset pulse at clock 150 clears calib_done without a clock edge
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_calib", calib_done, 0);
        chk("async_rst_cmd_full", p0_cmd_full, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (99) @(negedge clk);
        chk("recal99_done", calib_done, 0);
        @(negedge clk);
        chk("recal100_done", calib_done, 1);

        // Two-word write then read back at byte address 0x40
        wr_word(32'hA5A5_0001, 4'h0);
        wr_word(32'hA5A5_0002, 4'h0);
        chk("t2_wr_count", p0_wr_count, 2);
        cmd(3'b000, 30'h40, 6'd1);
        cmd(3'b001, 30'h40, 6'd1);
        wait_rd(2);
        chk("t2_rd_count2", p0_rd_count, 2);
        pop_chk("t2_word0", 32'hA5A5_0001);
        chk("t2_rd_count1", p0_rd_count, 1);
        pop_chk("t2_word1", 32'hA5A5_0002);
        chk("t2_rd_count0", p0_rd_count, 0);
        chk("t2_rd_empty", p0_rd_empty, 1);
        chk("t2_wr_count0", p0_wr_count, 0);

        // Read latency from an idle engine; byte_addr[1:0] is ignored
        cmd(3'b011, 30'h43, 6'd0);
        chk("lat_0", p0_rd_empty, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat_%0d", k), p0_rd_empty, (k < 4) ? 64'h1 : 64'h0);
        end
        pop_chk("lat_data", 32'hA5A5_0001);

        // Byte mask: mask bit i protects data bits [8i+7:8i]
        wr_word(32'hFFFF_FFFF, 4'b0000);
        cmd(3'b000, 30'h0, 6'd0);
        wr_word(32'h0000_0000, 4'b0101);
        cmd(3'b010, 30'h0, 6'd0);
        cmd(3'b001, 30'h0, 6'd0);
        wait_rd(1);
        pop_chk("t3_masked", 32'h00FF_00FF);

        // Write burst of 4 waits until all of its data is present
        wr_word(32'h1111_1111, 4'h0);
        wr_word(32'h2222_2222, 4'h0);
        cmd(3'b000, 30'h100, 6'd3);
        repeat (20) @(negedge clk);
        chk("t4_wait_count", p0_wr_count, 2);
        wr_word(32'h3333_3333, 4'h0);
        wr_word(32'h4444_4444, 4'h0);
        repeat (6) @(negedge clk);
        chk("t4_drained", p0_wr_count, 0);
        cmd(3'b001, 30'h100, 6'd3);
        wait_rd(4);
        chk("t4_rd_count", p0_rd_count, 4);
        pop_chk("t4_w0", 32'h1111_1111);
        pop_chk("t4_w1", 32'h2222_2222);
        pop_chk("t4_w2", 32'h3333_3333);
        pop_chk("t4_w3", 32'h4444_4444);

        // Address wrap: word 0xFFF is followed by word 0
        wr_word(32'hCAFE_0001, 4'h0);
        wr_word(32'hCAFE_0002, 4'h0);
        cmd(3'b000, 30'h3FFC, 6'd1);
        cmd(3'b001, 30'h0, 6'd0);
        wait_rd(1);
        pop_chk("t5_wrap", 32'hCAFE_0002);
        cmd(3'b001, 30'h3FFC, 6'd1);
        wait_rd(2);
        pop_chk("t5_top", 32'hCAFE_0001);
        pop_chk("t5_low", 32'hCAFE_0002);

        // Write FIFO overflow and read FIFO underrun
        chk("t6_ovf_pre", wr_overflow, 0);
        chk("t6_und_pre", rd_underrun, 0);
        p0_wr_en = 1'b1;
        p0_wr_mask = 4'h0;
        for (int i = 1; i <= 65; i++) begin
            p0_wr_data = 32'(i);
            @(negedge clk);
            if (i == 63) begin
                chk("t6_full63", p0_wr_full, 0);
                chk("t6_count63", p0_wr_count, 63);
            end
            if (i == 64) begin
                chk("t6_full64", p0_wr_full, 1);
                chk("t6_count64", p0_wr_count, 64);
                chk("t6_ovf64", wr_overflow, 0);
            end
            if (i == 65) begin
                chk("t6_ovf65", wr_overflow, 1);
                chk("t6_count65", p0_wr_count, 64);
            end
        end
        p0_wr_en = 1'b0;
        chk("t6_rd_empty", p0_rd_empty, 1);
        p0_rd_en = 1'b1;
        @(negedge clk);
        p0_rd_en = 1'b0;
        chk("t6_und", rd_underrun, 1);
        chk("t6_rd_count", p0_rd_count, 0);

        // Reset clears sticky flags and flushes the write FIFO
        reset = 1'b1;
        #1;
        chk("t6_rst_ovf", wr_overflow, 0);
        chk("t6_rst_und", rd_underrun, 0);
        chk("t6_rst_wr_count", p0_wr_count, 0);
        chk("t6_rst_wr_full", p0_wr_full, 1);
        chk("t6_rst_calib", calib_done, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
